// File: rtl/sevenseg_if.sv
// sevenseg_if: host-side bus of the seven-segment scan driver.
//   load        one-cycle strobe from the host; data_in/dp_in/blank_in are
//               sampled on the same rising edge. There is no back-pressure:
//               a load is always accepted, and a later load overwrites an
//               uncommitted earlier one.
//   data_in     hex nibble per digit (nibble i -> digit i)
//   dp_in       decimal point per digit
//   blank_in    force digit fully off
//   pending     driver -> host: shadow holds data not yet committed
//   frame_done  driver -> host: one-cycle pulse at each frame boundary
// Modports: master = register/status logic, slave = scan driver.
interface sevenseg_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output load, data_in, dp_in, blank_in,
    input  pending, frame_done
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    output pending, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed driver for NUM_DIGITS seven-segment
// digits sharing one segment bus. Hex decode 0-F plus decimal point, a
// blanking guard band at the start of every digit slot, and double-buffered
// display data that is committed only at frame boundaries.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   host     sevenseg_if.slave (load, data_in, dp_in, blank_in, pending,
//            frame_done)
//   seg_out  {dp,g,f,e,d,c,b,a}; inverted at the pins when SEG_ACTIVE_LOW=1
//   dig_sel  digit enables; active-low when DIG_ACTIVE_LOW=1
// Optional feature: define SEVENSEG_LZB_EN for leading-zero blanking.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  sevenseg_if.slave             host,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int          CW      = $clog2(REFRESH_DIV);
  localparam int          IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0] BLANK_U = BLANK_CYCLES;

  logic [CW-1:0]           cnt;
  logic [IDXW-1:0]         idx;
  logic                    tick;
  logic                    frame_end;
  logic                    in_blank;

  logic [4*NUM_DIGITS-1:0] shadow_data, active_data;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0]   shadow_blk, active_blk;
  logic                    pending_r;
  logic                    frame_done_r;

  // Logical (active-high) output registers; polarity applied at the pins.
  logic [7:0]              seg_r, seg_nxt;
  logic [NUM_DIGITS-1:0]   dig_r, dig_nxt;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blk;
  logic                    cur_sup;
  logic [NUM_DIGITS-1:0]   sup_mask;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick      = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == IDXW'(NUM_DIGITS - 1));
  assign in_blank  = ({{(32-CW){1'b0}}, cnt} < BLANK_U);

`ifdef SEVENSEG_LZB_EN
  // Walk down from the most significant digit; suppress zeros (without dp)
  // until the first significant digit. Digit 0 is never suppressed.
  logic lead;
  always_comb begin
    lead     = 1'b1;
    sup_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (active_data[i*4 +: 4] == 4'h0) && !active_dp[i]) begin
        sup_mask[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign sup_mask = '0;
`endif

  // Pick the active-buffer fields of the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_blk = 1'b0;
    cur_sup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDXW'(i)) begin
        cur_nib = active_data[i*4 +: 4];
        cur_dp  = active_dp[i];
        cur_blk = active_blk[i];
        cur_sup = sup_mask[i];
      end
    end
  end

  always_comb begin
    seg_nxt = 8'h00;
    dig_nxt = '0;
    if (!in_blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDXW'(i)) dig_nxt[i] = 1'b1;
      end
      // A blanked or suppressed digit keeps its enable but lights nothing.
      if (!(cur_blk || cur_sup)) seg_nxt = {cur_dp, hex7(cur_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blk   <= '0;
      active_data  <= '0;
      active_dp    <= '0;
      active_blk   <= '0;
      pending_r    <= 1'b0;
      frame_done_r <= 1'b0;
      seg_r        <= 8'h00;
      dig_r        <= '0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDXW'(NUM_DIGITS - 1)) ? '0 : idx + IDXW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      frame_done_r <= frame_end;
      seg_r        <= seg_nxt;
      dig_r        <= dig_nxt;

      // Commit copies the pre-edge shadow, so a coincident load lands in
      // the shadow for the following frame and keeps pending set.
      if (frame_end && pending_r) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
        active_blk  <= shadow_blk;
      end

      if (host.load) begin
        shadow_data <= host.data_in;
        shadow_dp   <= host.dp_in;
        shadow_blk  <= host.blank_in;
        pending_r   <= 1'b1;
      end else if (frame_end && pending_r) begin
        pending_r   <= 1'b0;
      end
    end
  end

  assign host.pending    = pending_r;
  assign host.frame_done = frame_done_r;
  assign seg_out         = seg_r ^ {8{SEG_ACTIVE_LOW}};
  assign dig_sel         = dig_r ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;

  logic clk;
  logic rst;
  logic [7:0] seg_out;
  logic [3:0] dig_sel;

  int n_checks = 0;
  int n_fail   = 0;

  sevenseg_if #(.NUM_DIGITS(4)) bus ();

  sevenseg_scan_driver #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (bus.slave),
    .seg_out (seg_out),
    .dig_sel (dig_sel)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_data(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blk);
    bus.load     = 1'b1;
    bus.data_in  = d;
    bus.dp_in    = dp;
    bus.blank_in = blk;
    step();
    bus.load     = 1'b0;
  endtask

  // Advance until frame_done is seen at a negedge (bounded).
  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (bus.frame_done) seen = 1'b1;
    end
    check({tag, " frame_done seen"}, 32'(seen), 32'd1);
  endtask

  // Called at the negedge right after a frame_done edge; checks the 16
  // cycles of the next frame and ends on the following frame_done.
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_seg [4];
    logic [3:0] exp_dig;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (c == 0) begin
          check($sformatf("%s d%0d guard seg", tag, s), 32'(seg_out), 32'h00);
          check($sformatf("%s d%0d guard dig", tag, s), 32'(dig_sel), 32'hF);
        end else begin
          exp_dig = ~(4'b0001 << s);
          check($sformatf("%s d%0d c%0d seg", tag, s, c), 32'(seg_out), 32'(exp_seg[s]));
          check($sformatf("%s d%0d c%0d dig", tag, s, c), 32'(dig_sel), 32'(exp_dig));
        end
        check($sformatf("%s d%0d c%0d frame_done", tag, s, c), 32'(bus.frame_done),
              (s == 3 && c == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bit got_fd;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;

    // 1. reset and first frame
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst seg", 32'(seg_out), 32'h00);
    check("rst dig", 32'(dig_sel), 32'hF);
    check("rst pending", 32'(bus.pending), 32'd0);
    check("rst frame_done", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    step();
    check("post-rst c1 dig", 32'(dig_sel), 32'hF);
    step();
    check("post-rst c2 dig", 32'(dig_sel), 32'hE);
    check("post-rst c2 seg", 32'(seg_out), 32'h3F);
    k = 2;
    got_fd = 1'b0;
    while (k < 40 && !got_fd) begin
      step();
      k++;
      if (bus.frame_done) got_fd = 1'b1;
    end
    check("first frame_done cycle", 32'(k), 32'd16);

    // 2. single load, commit at next boundary
    load_data(16'hA5F0, 4'b0010, 4'b0000);
    check("t2 pending after load", 32'(bus.pending), 32'd1);
    wait_frame("t2");
    check("t2 pending at commit", 32'(bus.pending), 32'd0);
    check_frame("t2", 8'h3F, 8'hF1, 8'h6D, 8'h77);

    // 3. two loads in one frame: last wins
    load_data(16'h1234, 4'b0000, 4'b0000);
    step();
    load_data(16'h5678, 4'b0000, 4'b0000);
    wait_frame("t3");
    check_frame("t3", 8'h7F, 8'h07, 8'h7D, 8'h6D);

    // 4. load coincident with a commit (we are at the frame_done negedge)
    load_data(16'h3210, 4'b0000, 4'b0000);
    repeat (14) step();
    check("t4 pre-boundary frame_done", 32'(bus.frame_done), 32'd0);
    load_data(16'hBCDE, 4'b0000, 4'b0000);
    check("t4 boundary frame_done", 32'(bus.frame_done), 32'd1);
    check("t4 pending held", 32'(bus.pending), 32'd1);
    check_frame("t4a", 8'h3F, 8'h06, 8'h5B, 8'h4F);
    check("t4 pending after 2nd commit", 32'(bus.pending), 32'd0);
    check_frame("t4b", 8'h79, 8'h5E, 8'h39, 8'h7C);

    // 5. blanked digit, then remaining decode entries
    load_data(16'h8888, 4'b0000, 4'b0100);
    wait_frame("t5");
    check_frame("t5", 8'h7F, 8'h7F, 8'h00, 8'h7F);
    load_data(16'h4949, 4'b0000, 4'b0000);
    wait_frame("t5b");
    check_frame("t5b", 8'h6F, 8'h66, 8'h6F, 8'h66);

    // 6. leading zeros
    load_data(16'h0070, 4'b0000, 4'b0000);
    wait_frame("t6");
`ifdef SEVENSEG_LZB_EN
    check_frame("t6 lzb", 8'h3F, 8'h07, 8'h00, 8'h00);
    load_data(16'h0000, 4'b0000, 4'b0000);
    wait_frame("t6b");
    check_frame("t6b lzb", 8'h3F, 8'h00, 8'h00, 8'h00);
`else
    check_frame("t6 no-lzb", 8'h3F, 8'h07, 8'h3F, 8'h3F);
`endif

    // 7. reset mid-frame with a load pending
    load_data(16'hFFFF, 4'b1111, 4'b0000);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("mid-rst seg", 32'(seg_out), 32'h00);
    check("mid-rst dig", 32'(dig_sel), 32'hF);
    check("mid-rst pending", 32'(bus.pending), 32'd0);
    rst = 1'b0;
    step();
    check("mid-rst c1 dig", 32'(dig_sel), 32'hF);
    step();
    check("mid-rst c2 dig", 32'(dig_sel), 32'hE);
    check("mid-rst c2 seg", 32'(seg_out), 32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits sharing one segment bus. It decodes hex digits 0-F plus decimal point and scans the digits at a programmable refresh rate. A blanking guard band at the start of each digit slot prevents ghosting. New display data is double-buffered and committed only at frame boundaries, so the display never tears. It sits between the register/status logic and the board segment/digit pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal 1..8
REFRESH_DIV, 50000, clk cycles per digit slot; legal >= 2
BLANK_CYCLES, 2, cycles at the start of each slot with all digits off; legal 0..REFRESH_DIV-1
SEG_ACTIVE_LOW, 0, 1 inverts seg_out at the pins
DIG_ACTIVE_LOW, 1, 1 means a digit is enabled by driving its dig_sel bit low

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  one-cycle strobe; captures data_in/dp_in/blank_in into the shadow buffer
data_in  in  4*NUM_DIGITS  hex nibble per digit; nibble i drives digit i; digit 0 is least significant
dp_in  in  NUM_DIGITS  decimal point per digit
blank_in  in  NUM_DIGITS  force digit fully off
pending  out  1  shadow holds data not yet committed
frame_done  out  1  one-cycle pulse at each frame boundary
seg_out  out  8  {dp,g,f,e,d,c,b,a}, logical 1 = lit before polarity
dig_sel  out  NUM_DIGITS  digit enables, polarity per DIG_ACTIVE_LOW

Behaviour:
- Reset: prescaler=0, digit index=0, shadow and active buffers=0, pending=0, frame_done=0, seg_out=all off (0x00, or 0xFF if SEG_ACTIVE_LOW), dig_sel=all inactive.
- Prescaler: counts 0..REFRESH_DIV-1. tick is asserted when the count equals REFRESH_DIV-1. On tick, the count wraps to 0 and the index advances; NUM_DIGITS-1 wraps to 0.
- Frame boundary: a tick while index==NUM_DIGITS-1. With NUM_DIGITS=1, every tick is a frame boundary.
- Decode table (logical segments): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Bit7 = dp of the selected digit.
- Outputs are registered, with 1-cycle latency from prescaler/index state.
- While the prescaler < BLANK_CYCLES: dig_sel is all inactive and seg_out is all off. Otherwise: dig_sel enables only the current index, and seg_out is the decode of active[index].
- Blanked digit (blank_in bit set when loaded): seg_out all off, including dp. dig_sel still asserts normally.
- load: shadow <= inputs; pending <= 1. Multiple loads before a commit: last one wins.
- Commit on frame boundary when pending=1: active <= shadow; pending <= 0. The new data first appears in the digit-0 slot.
- load in the same cycle as a commit: the commit takes the old shadow, the new data enters the shadow, and pending stays 1.
- frame_done pulses on every frame boundary, whether or not a commit occurs.
- Reset mid-frame: all state returns to reset values on the next edge, and scanning restarts at digit 0.

Optional Feature:
SEVENSEG_LZB_EN: leading-zero blanking.
- Defined: scanning from digit NUM_DIGITS-1 downward, each digit whose active nibble is 0 with dp=0 is blanked until the first nonzero nibble or set dp. Digit 0 is never suppressed.
- Not defined: all digits are displayed as decoded and the logic is absent.

Test Plan:
Bench parameters for all cases: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1.
1. Hold rst 3 cycles, then release -> seg_out=00 and dig_sel=1111 during reset. First enabled output is dig_sel=1110 two cycles after release. frame_done first pulses 16 cycles after release.
2. load data_in=16'hA5F0, dp_in=4'b0010, then wait for commit -> pending=1 until the frame_done cycle, then 0. Next frame per slot: dig0 seg=3F/dig_sel 1110; dig1 seg=F1/1101; dig2 seg=6D/1011; dig3 seg=77/0111. Exactly one all-off cycle per 4-cycle slot.
3. Two loads (16'h1234, then 16'h5678) within one frame -> only 5678 is ever displayed. 1234 never appears.
4. load asserted on the exact frame-boundary cycle with pending=1 -> the next frame shows the prior shadow. The new value shows one frame later, and pending stays 1 across the first boundary.
5. blank_in=4'b0100 with data 16'h8888 -> digit 2 slot shows seg_out=00 with dig_sel=1011. The other digits show 7F.
6. (SEVENSEG_LZB_EN) data 16'h0070, dp=0 -> digits 3 and 2 are off, digit 1 shows 07, digit 0 shows 3F. With 16'h0000, only digit 0 shows 3F.
